// File: rtl/pattern_gen.sv
// Width-configurable test-pattern source: saturating/wrapping count, Galois LFSR or
// constant words, offered on a valid/ready stream with a saturating transfer counter.
module pattern_gen #(
   parameter int unsigned             WIDTH     = 16,
   parameter logic [WIDTH-1:0]        LFSR_TAPS = WIDTH'(16'hB400),
   parameter int unsigned             CNT_W     = 32
) (
   input  logic             clk,
   input  logic             rst_h,
   input  logic             ena,
   input  logic             load,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] step,
   input  logic [WIDTH-1:0] limit,
   input  logic [WIDTH-1:0] seed,
   input  logic             ready,
   output logic [WIDTH-1:0] data,
   output logic             valid,
   output logic             done,
   output logic [CNT_W-1:0] beats
);

   localparam logic [1:0] M_SAT   = 2'd0;
   localparam logic [1:0] M_WRAP  = 2'd1;
   localparam logic [1:0] M_LFSR  = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             done_q, done_d;
   logic [CNT_W-1:0] beats_q, beats_d;

   logic             xfer;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] next_word;

   assign xfer = valid_q & ready;

   // Next pattern word; sum carries one extra bit so overflow compares above limit.
   always_comb begin
      sum       = {1'b0, data_q} + {1'b0, step};
      next_word = data_q;
      case (mode)
         M_SAT: begin
            if ((data_q > limit) || (sum > {1'b0, limit})) next_word = limit;
            else                                           next_word = sum[WIDTH-1:0];
         end
         M_WRAP: begin
            if (sum > {1'b0, limit}) next_word = seed;
            else                     next_word = sum[WIDTH-1:0];
         end
         M_LFSR: begin
            if (data_q == '0)    next_word = WIDTH'(1);
            else if (data_q[0])  next_word = (data_q >> 1) ^ LFSR_TAPS;
            else                 next_word = data_q >> 1;
         end
         default: next_word = data_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      valid_d = valid_q;
      done_d  = done_q;
      beats_d = beats_q;

      if (xfer && (beats_q != '1)) beats_d = beats_q + CNT_W'(1);

      // Load wins over the state machine; a coincident transfer only counts.
      if (load) begin
         data_d  = ((mode == M_LFSR) && (seed == '0)) ? WIDTH'(1) : seed;
         state_d = S_IDLE;
         valid_d = 1'b0;
         done_d  = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (ena) begin
                  state_d = S_RUN;
                  valid_d = 1'b1;
               end
            end
            S_RUN: begin
               if (xfer) data_d = next_word;
               if (xfer && (mode == M_SAT) && (data_q == limit)) begin
                  state_d = S_DONE;
                  valid_d = 1'b0;
                  done_d  = 1'b1;
               end else if (!ena) begin
                  state_d = S_IDLE;
                  valid_d = 1'b0;
               end
            end
            S_DONE: begin
               valid_d = 1'b0;
               done_d  = 1'b1;
            end
            default: begin
               state_d = S_IDLE;
               valid_d = 1'b0;
               done_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst_h) begin
      if (rst_h) begin
         state_q <= S_IDLE;
         data_q  <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         beats_q <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         done_q  <= done_d;
         beats_q <= beats_d;
      end
   end

   assign data  = data_q;
   assign valid = valid_q;
   assign done  = done_q;
   assign beats = beats_q;

endmodule

// File: tb/tb_pattern_gen.sv
// Bench for pattern_gen: directed scenarios plus random stimulus, all checked
// cycle by cycle against a behavioural model of the generator.
module tb_pattern_gen;

   localparam int unsigned W    = 16;
   localparam int unsigned CW   = 32;
   localparam logic [15:0] TAPS = 16'hB400;

   logic          clk   = 1'b0;
   logic          rst_h = 1'b1;
   logic          ena   = 1'b0;
   logic          load  = 1'b0;
   logic [1:0]    mode  = 2'd0;
   logic [W-1:0]  step  = '0;
   logic [W-1:0]  limit = '0;
   logic [W-1:0]  seed  = '0;
   logic          ready = 1'b0;
   logic [W-1:0]  data;
   logic          valid;
   logic          done;
   logic [CW-1:0] beats;

   pattern_gen #(.WIDTH(W), .LFSR_TAPS(TAPS), .CNT_W(CW)) dut (
      .clk(clk), .rst_h(rst_h), .ena(ena), .load(load), .mode(mode),
      .step(step), .limit(limit), .seed(seed), .ready(ready),
      .data(data), .valid(valid), .done(done), .beats(beats)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Behavioural model state: word on offer, whether it is offered, finished flag, count.
   logic [W-1:0]    m_data  = '0;
   bit              m_valid = 1'b0;
   bit              m_done  = 1'b0;
   longint unsigned m_beats = 0;
   logic [W-1:0]    xq[$];

   function automatic logic [W-1:0] ref_next(input logic [1:0] md, input logic [W-1:0] d,
                                             input logic [W-1:0] st, input logic [W-1:0] lim,
                                             input logic [W-1:0] sd);
      int unsigned s;
      s = 32'(d) + 32'(st);
      case (md)
         2'd0: begin
            if (d > lim) return lim;
            return (s > 32'(lim)) ? lim : W'(s);
         end
         2'd1: return (s > 32'(lim)) ? sd : W'(s);
         2'd2: begin
            if (d == 0) return W'(1);
            return (d % 2 == 1) ? ((d / 2) ^ TAPS) : (d / 2);
         end
         default: return d;
      endcase
   endfunction

   always @(posedge clk or posedge rst_h) begin
      bit x;
      bit fin;
      if (rst_h) begin
         m_data = '0; m_valid = 0; m_done = 0; m_beats = 0;
      end else begin
         x = m_valid && ready;
         if (x && m_beats < 64'hFFFF_FFFF) m_beats = m_beats + 1;
         if (load) begin
            m_data  = (mode == 2'd2 && seed == 0) ? W'(1) : seed;
            m_valid = 0;
            m_done  = 0;
         end else if (m_done) begin
            m_valid = 0;
         end else if (!m_valid) begin
            if (ena) m_valid = 1;
         end else begin
            fin = x && mode == 2'd0 && m_data == limit;
            if (x) m_data = ref_next(mode, m_data, step, limit, seed);
            if (fin) begin
               m_valid = 0;
               m_done  = 1;
            end else if (!ena) begin
               m_valid = 0;
            end
         end
      end
   end

   always @(posedge clk) begin
      if (!rst_h && valid && ready) xq.push_back(data);
   end

   always @(posedge clk) begin
      #1;
      total++;
      if (data !== m_data || valid !== m_valid || done !== m_done || beats !== CW'(m_beats)) begin
         bad++;
         $display("FAIL cycle_cmp t=%0t got d=%h v=%b dn=%b b=%0d want d=%h v=%b dn=%b b=%0d",
                  $time, data, valid, done, beats, m_data, m_valid, m_done, m_beats);
      end
   end

   task automatic chk(input string nm, input longint unsigned got, input longint unsigned exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", nm, got, exp);
      end
   endtask

   task automatic do_load(input logic [1:0] md, input logic [W-1:0] sd,
                          input logic [W-1:0] st, input logic [W-1:0] lim);
      @(negedge clk);
      load = 1'b1; mode = md; seed = sd; step = st; limit = lim;
      @(negedge clk);
      load = 1'b0;
      xq.delete();
   endtask

   task automatic wait_done(input int lim);
      int n = 0;
      while (!done && n < lim) begin
         @(negedge clk);
         n++;
      end
      chk("done_reached", longint'(done), 1);
   endtask

   task automatic wait_xq(input int cnt, input int lim);
      int n = 0;
      while (xq.size() < cnt && n < lim) begin
         @(negedge clk);
         n++;
      end
      chk("xfer_count_reached", longint'(xq.size() >= cnt), 1);
   endtask

   task automatic chk_seq(input string nm, input logic [W-1:0] e0, input logic [W-1:0] e1,
                          input logic [W-1:0] e2, input logic [W-1:0] e3,
                          input logic [W-1:0] e4, input logic [W-1:0] e5, input int n,
                          input bit exact);
      logic [W-1:0] exp[6];
      exp = '{e0, e1, e2, e3, e4, e5};
      if (exact) chk({nm, "_len"}, longint'(xq.size()), longint'(n));
      for (int i = 0; i < n; i++)
         chk($sformatf("%s_w%0d", nm, i), (i < xq.size()) ? longint'(xq[i]) : 64'hDEAD_BEEF,
             longint'(exp[i]));
   endtask

   initial begin
      logic [W-1:0] d0;
      logic [CW-1:0] b0;
      int rep;

      repeat (2) @(negedge clk);
      chk("rst_data", data, 0);
      chk("rst_valid", valid, 0);
      chk("rst_done", done, 0);
      chk("rst_beats", beats, 0);
      rst_h = 1'b0;

      // Pin the reference model with hand-computed values.
      chk("model_lfsr1", ref_next(2'd2, 16'h0001, 0, 0, 0), 16'hB400);
      chk("model_lfsr2", ref_next(2'd2, 16'hB400, 0, 0, 0), 16'h5A00);
      chk("model_sat_ovf", ref_next(2'd0, 16'hFFFE, 16'd5, 16'hFFFF, 0), 16'hFFFF);
      chk("model_wrap", ref_next(2'd1, 16'd6, 16'd2, 16'd6, 16'd2), 16'd2);

      // SAT 0..5
      ready = 1'b1;
      do_load(2'd0, 16'd0, 16'd1, 16'd5);
      ena = 1'b1;
      wait_done(40);
      chk_seq("sat1", 0, 1, 2, 3, 4, 5, 6, 1'b1);
      chk("sat1_valid", valid, 0);
      chk("sat1_beats", beats, 6);

      // SAT step 3 limit 7
      do_load(2'd0, 16'd0, 16'd3, 16'd7);
      wait_done(40);
      chk_seq("sat3", 0, 3, 6, 7, 0, 0, 4, 1'b1);

      // SAT near top of range: no overflow
      do_load(2'd0, 16'hFFFE, 16'd5, 16'hFFFF);
      wait_done(40);
      chk_seq("satovf", 16'hFFFE, 16'hFFFF, 0, 0, 0, 0, 2, 1'b1);

      // WRAP
      do_load(2'd1, 16'd2, 16'd2, 16'd6);
      wait_xq(6, 40);
      chk_seq("wrap", 2, 4, 6, 2, 4, 6, 6, 1'b0);
      chk("wrap_done", done, 0);
      ena = 1'b0;

      // LFSR and its period
      do_load(2'd2, 16'd0, 16'd0, 16'd0);
      ena = 1'b1;
      wait_xq(65536, 70000);
      ena = 1'b0;
      chk_seq("lfsr", 16'h0001, 16'hB400, 16'h5A00, 0, 0, 0, 3, 1'b0);
      rep = 0;
      for (int i = 1; i < xq.size(); i++) begin
         if (xq[i] == xq[0]) begin
            rep = i;
            break;
         end
      end
      chk("lfsr_period", longint'(rep), 65535);
      xq.delete();

      // Backpressure: ready 1,0,0,1
      do_load(2'd0, 16'd10, 16'd1, 16'd1000);
      ena = 1'b1;
      ready = 1'b1;
      @(negedge clk);
      chk("bp_valid", valid, 1);
      d0 = data; b0 = beats;
      @(negedge clk); ready = 1'b0;
      chk("bp_adv1", data, longint'(d0) + 1);
      @(negedge clk);
      chk("bp_hold1_d", data, longint'(d0) + 1);
      chk("bp_hold1_v", valid, 1);
      @(negedge clk); ready = 1'b1;
      chk("bp_hold2_d", data, longint'(d0) + 1);
      chk("bp_hold2_b", beats, longint'(b0) + 1);
      @(negedge clk);
      chk("bp_adv2", data, longint'(d0) + 2);
      chk("bp_beats", beats, longint'(b0) + 2);

      // ena drops in the cycle of a transfer
      ena = 1'b0;
      @(negedge clk);
      chk("edrop_valid", valid, 0);
      chk("edrop_beats", beats, longint'(b0) + 3);
      chk("edrop_data", data, longint'(d0) + 3);
      @(negedge clk);
      chk("edrop_hold", data, longint'(d0) + 3);

      // load while in DONE
      do_load(2'd0, 16'd0, 16'd1, 16'd2);
      ena = 1'b1;
      wait_done(20);
      ena = 1'b0;
      do_load(2'd0, 16'h1234, 16'd1, 16'd2);
      chk("ld_done", done, 0);
      chk("ld_data", data, 16'h1234);
      chk("ld_valid", valid, 0);

      // Random traffic
      for (int c = 0; c < 1500; c++) begin
         @(negedge clk);
         ena   = ($urandom_range(0, 9) != 0);
         ready = ($urandom_range(0, 3) != 0);
         load  = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 9) == 0) step = W'($urandom_range(0, 7));
         if ($urandom_range(0, 9) == 0)
            limit = ($urandom_range(0, 7) == 0) ? W'($urandom) : W'($urandom_range(0, 60));
         if ($urandom_range(0, 9) == 0)
            seed = ($urandom_range(0, 7) == 0) ? W'($urandom) : W'($urandom_range(0, 70));
      end
      @(negedge clk);
      load = 1'b0;

      // Asynchronous reset mid-stream
      do_load(2'd1, 16'd0, 16'd1, 16'd100);
      ena = 1'b1;
      ready = 1'b1;
      repeat (5) @(negedge clk);
      chk("pre_rst_beats_nz", longint'(beats != 0), 1);
      #2 rst_h = 1'b1;
      #1;
      chk("arst_data", data, 0);
      chk("arst_valid", valid, 0);
      chk("arst_done", done, 0);
      chk("arst_beats", beats, 0);
      @(negedge clk);
      rst_h = 1'b0;
      ena = 1'b0;
      repeat (3) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pattern_gen.md
# pattern_gen

Parametrised test-pattern source for the APB-attached data path. It replaces the fixed 16-bit saturating up-counter with a width-configurable generator offering four modes: saturating count, wrapping count, LFSR and constant. Every word is presented on a valid/ready stream and counted. It sits between the control registers (mode/step/limit/seed) and the downstream consumer or FIFO under test.

## Interface
- WIDTH, 16, data word width (2..32)
- LFSR_TAPS, 16'hB400, Galois feedback mask, WIDTH bits
- CNT_W, 32, width of the transferred-beat counter
- clk  in  1  clock, rising edge
- rst_h  in  1  reset, asynchronous, active-high
- ena  in  1  run enable, level
- load  in  1  single-cycle pulse, reloads `seed`
- mode  in  2  0=SAT, 1=WRAP, 2=LFSR, 3=CONST
- step  in  WIDTH  increment for SAT/WRAP
- limit  in  WIDTH  upper bound for SAT/WRAP
- seed  in  WIDTH  load value and WRAP restart value
- ready  in  1  consumer accepts `data` this cycle
- data  out  WIDTH  current pattern word, registered
- valid  out  1  `data` is offered, registered
- done  out  1  SAT sequence finished, registered
- beats  out  CNT_W  number of completed transfers, saturating

## Operation
- A transfer occurs when `valid && ready`. `data` and `valid` must not change while `valid=1 && ready=0`.
- States:
  - IDLE: `valid=0`.
  - RUN: `valid=1`.
  - DONE: `valid=0`, `done=1`.
- IDLE -> RUN when `ena=1`.
- RUN -> IDLE when `ena=0`. If a transfer happens in the same cycle, the word is still consumed and `data` advances.
- RUN -> DONE after a transfer in SAT mode of a word equal to `limit`.
- DONE is left only by `load` or reset.
- `load`:
  - Has priority over everything except reset.
  - `data<=seed`; in LFSR mode, seed 0 is replaced by 1.
  - State goes to IDLE, `done<=0`. `beats` is not cleared.
  - A transfer coincident with `load` is counted in `beats`, but its advanced value is discarded.
- Next-value rule, applied on each transfer. Uses the `mode`, `step` and `limit` values present in that cycle. Sums are computed WIDTH+1 bits wide, with no silent overflow.
  - SAT: `next = min(data+step, limit)`. If `data > limit` (seed above limit), `next = limit`.
  - WRAP: `next = data+step`. If this is greater than `limit`, `next = seed`. Never sets `done`.
  - LFSR: `next = data[0] ? (data>>1) ^ LFSR_TAPS : data>>1`. A `data` of 0 gives `next=1`. Never sets `done`.
  - CONST: `next = data`.
- `beats` increments by 1 on each transfer and holds at all-ones.
- A mode change mid-run takes effect at the next transfer. There is no reload on mode change.

## Timing
- Reset values: `data=0`, `valid=0`, `done=0`, `beats=0`, state IDLE.
- `valid` rises 1 cycle after `ena` is sampled high in IDLE.
- One word per cycle at full throughput when `ready=1` continuously.
- `data` updates on the edge that completes the transfer. The new word is visible in the following cycle.
- `done` rises, and `valid` falls, on the edge after the transfer of `limit`.
- `load` is effective on the edge where it is sampled. `valid=0` in the next cycle.
- Reset mid-run aborts immediately (asynchronous). There is no partial transfer; `beats` returns to 0.

## Test plan
- Reset then SAT mode, `seed=0` via `load`, `step=1`, `limit=5`, `ena=1`, `ready=1`:
  - `data` sequence 0,1,2,3,4,5.
  - `done=1` and `valid=0` on the next cycle.
  - `beats=6`.
- SAT mode, `seed=0`, `step=3`, `limit=7`: sequence 0,3,6,7, then DONE. Repeat with `WIDTH=16`, `seed=16'hFFFE`, `step=5`, `limit=16'hFFFF`: sequence FFFE, FFFF, with no overflow to 0003.
- WRAP mode, `seed=2`, `step=2`, `limit=6`, `ready=1`: sequence 2,4,6,2,4,6. `done` stays 0.
- LFSR mode, `WIDTH=16`, `seed=0` loaded: first word 1, second 16'hB400, third 16'h5A00. Check the maximal period 65535 before the first repeat.
- Backpressure: RUN, then `ready` toggled 1,0,0,1. `data` and `valid` are held stable through the stall. `beats` increments only on the two accepted cycles.
- Edge events:
  - `ena` drops in the same cycle as a transfer: the word is counted, state goes IDLE, and the next value is held.
  - `load` asserted in DONE: `done=0`, `data=seed`.
  - `rst_h` pulse mid-stream: all outputs return to 0 at once.
